// File: rtl/alu_issue_unit_if.sv
// Instruction handshake and ALU port bundle for alu_issue_unit.
// The slave modport is the issue unit; the master modport is the fetch/decode side plus the ALU.
interface alu_issue_unit_if #(
    parameter int unsigned WORD_SIZE = 8
) ();

    logic                 instr_valid;
    logic                 instr_ready;
    logic [3:0]           instr_op;
    logic [1:0]           instr_dst;
    logic [1:0]           instr_src;
    logic [WORD_SIZE-1:0] instr_imm;
    logic                 instr_use_imm;

    logic [WORD_SIZE-1:0] alu_a;
    logic [WORD_SIZE-1:0] alu_b;
    logic [3:0]           alu_mode;
    logic [WORD_SIZE-1:0] alu_c;
    logic [7:0]           alu_flags;

    modport master (
        output instr_valid,
        output instr_op,
        output instr_dst,
        output instr_src,
        output instr_imm,
        output instr_use_imm,
        input  instr_ready,
        input  alu_a,
        input  alu_b,
        input  alu_mode,
        output alu_c,
        output alu_flags
    );

    modport slave (
        input  instr_valid,
        input  instr_op,
        input  instr_dst,
        input  instr_src,
        input  instr_imm,
        input  instr_use_imm,
        output instr_ready,
        output alu_a,
        output alu_b,
        output alu_mode,
        input  alu_c,
        input  alu_flags
    );

endinterface

// File: rtl/alu_issue_unit.sv
// Execute-stage issue controller: owns a 4-entry register file and drives an external ALU.
// Define ALU_ISSUE_FAST_EN to drop the SAMPLE state (capture at end of DRIVE, 3-cycle issue).
module alu_issue_unit #(
    parameter int unsigned WORD_SIZE = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    alu_issue_unit_if.slave      bus,
    output logic                 wb_valid_o,
    output logic [1:0]           wb_reg_o,
    output logic [WORD_SIZE-1:0] wb_data_o,
    output logic [7:0]           flags_q_o,
    input  logic [1:0]           rd_sel_i,
    output logic [WORD_SIZE-1:0] rd_data_o
);

    typedef enum logic [1:0] {StIdle, StDrive, StSample, StWb} state_e;

    localparam logic [3:0] OpNop   = 4'd0;
    localparam logic [3:0] OpCmp   = 4'd2;
    localparam logic [3:0] OpTest  = 4'd3;
    localparam logic [3:0] OpClear = 4'd15;

    state_e               state_q, state_d;
    logic                 live_q;
    logic [3:0]           op_q, op_d;
    logic [1:0]           dst_q, dst_d;
    logic [WORD_SIZE-1:0] a_q, a_d;
    logic [WORD_SIZE-1:0] b_q, b_d;
    logic [WORD_SIZE-1:0] c_q, c_d;
    logic [7:0]           cflags_q, cflags_d;
    logic [7:0]           flags_q, flags_d;
    logic [WORD_SIZE-1:0] regs_q [4];

    logic accept;
    logic drive_en;
    logic capture;
    logic wr_en;
    logic op_writes;

    // live_q keeps instr_ready low while rst is asserted and until the first edge after release.
    assign bus.instr_ready = live_q && (state_q == StIdle);
    assign accept          = bus.instr_valid && bus.instr_ready;
    assign drive_en        = (state_q == StDrive) || (state_q == StSample);

`ifdef ALU_ISSUE_FAST_EN
    assign capture = (state_q == StDrive);
`else
    assign capture = (state_q == StSample);
`endif

    assign op_writes = !((op_q == OpNop) || (op_q == OpCmp) ||
                         (op_q == OpTest) || (op_q == OpClear));
    assign wr_en     = (state_q == StWb) && op_writes;

    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        dst_d    = dst_q;
        a_d      = a_q;
        b_d      = b_q;
        c_d      = c_q;
        cflags_d = cflags_q;
        flags_d  = flags_q;

        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    state_d = StDrive;
                    op_d    = bus.instr_op;
                    dst_d   = bus.instr_dst;
                    a_d     = regs_q[bus.instr_dst];
                    b_d     = bus.instr_use_imm ? bus.instr_imm : regs_q[bus.instr_src];
                end
            end
            StDrive: begin
`ifdef ALU_ISSUE_FAST_EN
                state_d = StWb;
`else
                state_d = StSample;
`endif
            end
            StSample: begin
                state_d = StWb;
            end
            StWb: begin
                state_d = StIdle;
                case (op_q)
                    OpNop:   flags_d = flags_q;
                    OpClear: flags_d = 8'h00;
                    // TEST only reports Z and S; C and O are forced clear.
                    OpTest:  flags_d = {cflags_q[7:6], 6'b000000};
                    default: flags_d = cflags_q;
                endcase
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        if (capture) begin
            c_d      = bus.alu_c;
            cflags_d = bus.alu_flags;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= StIdle;
            live_q   <= 1'b0;
            op_q     <= OpNop;
            dst_q    <= 2'd0;
            a_q      <= '0;
            b_q      <= '0;
            c_q      <= '0;
            cflags_q <= 8'h00;
            flags_q  <= 8'h00;
            for (int i = 0; i < 4; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            state_q  <= state_d;
            live_q   <= 1'b1;
            op_q     <= op_d;
            dst_q    <= dst_d;
            a_q      <= a_d;
            b_q      <= b_d;
            c_q      <= c_d;
            cflags_q <= cflags_d;
            flags_q  <= flags_d;
            if (wr_en) begin
                regs_q[dst_q] <= c_q;
            end
        end
    end

    // Ports are decoded from state so an asynchronous reset returns them to NOP at once.
    assign bus.alu_a    = drive_en ? a_q : '0;
    assign bus.alu_b    = drive_en ? b_q : '0;
    assign bus.alu_mode = drive_en ? op_q : OpNop;

    assign wb_valid_o = wr_en;
    assign wb_reg_o   = wr_en ? dst_q : 2'd0;
    assign wb_data_o  = wr_en ? c_q : '0;
    assign flags_q_o  = flags_q;
    assign rd_data_o  = regs_q[rd_sel_i];

endmodule

// File: tb/tb_alu_issue_unit.sv
// Self-checking bench for alu_issue_unit with a behavioural ALU and a writeback scoreboard.
module tb_alu_issue_unit;

`ifdef ALU_ISSUE_FAST_EN
    localparam int WB_OFF  = 1;
    localparam int RDY_OFF = 2;
    localparam int PERIOD  = 3;
    localparam int ACT     = 1;
`else
    localparam int WB_OFF  = 2;
    localparam int RDY_OFF = 3;
    localparam int PERIOD  = 4;
    localparam int ACT     = 2;
`endif

    typedef struct {
        logic [1:0] r;
        logic [7:0] d;
    } wb_t;

    logic       clk;
    logic       rst;
    logic       wb_valid;
    logic [1:0] wb_reg;
    logic [7:0] wb_data;
    logic [7:0] flags_q;
    logic [1:0] rd_sel;
    logic [7:0] rd_data;

    int n_tests;
    int n_fail;
    int cyc;
    int accept_cyc;
    int active_cnt;

    wb_t        wb_q[$];
    logic [7:0] ref_regs [4];
    logic [7:0] ref_flags;
    logic       ref_carry;

    logic        alu_carry_q;
    logic        alu_pend_q;
    logic        alu_pend_v_q;
    logic [16:0] alu_res;

    alu_issue_unit_if #(.WORD_SIZE(8)) bus ();

    alu_issue_unit #(.WORD_SIZE(8)) dut (
        .clk        (clk),
        .rst        (rst),
        .bus        (bus),
        .wb_valid_o (wb_valid),
        .wb_reg_o   (wb_reg),
        .wb_data_o  (wb_data),
        .flags_q_o  (flags_q),
        .rd_sel_i   (rd_sel),
        .rd_data_o  (rd_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural ALU: returns {carry_out, flags, result}.
    function automatic logic [16:0] alu_eval(input logic [7:0] a, input logic [7:0] b,
                                             input logic [3:0] m, input logic cin);
        logic [8:0]  r;
        logic [15:0] p;
        logic [7:0]  c;
        logic        cf;
        logic        of;
        r  = '0;
        p  = '0;
        c  = '0;
        cf = 1'b0;
        of = 1'b0;
        case (m)
            4'd1: c = b;
            4'd2, 4'd8: begin
                r  = {1'b0, a} - {1'b0, b};
                c  = r[7:0];
                cf = r[8];
                of = (a[7] != b[7]) && (c[7] != a[7]);
            end
            4'd3: c = a & b;
            4'd4: begin c = {a[6:0], 1'b0}; cf = a[7]; end
            4'd5: begin c = {1'b0, a[7:1]}; cf = a[0]; end
            4'd6, 4'd7: begin
                r  = {1'b0, a} + {1'b0, b} + {8'd0, cin & (m == 4'd7)};
                c  = r[7:0];
                cf = r[8];
                of = (a[7] == b[7]) && (c[7] != a[7]);
            end
            4'd9: begin
                r  = {1'b0, a} - {1'b0, b} - {8'd0, cin};
                c  = r[7:0];
                cf = r[8];
                of = (a[7] != b[7]) && (c[7] != a[7]);
            end
            4'd10: begin
                p  = {8'd0, a} * {8'd0, b};
                c  = p[7:0];
                cf = |p[15:8];
                of = cf;
            end
            4'd11: c = a & b;
            4'd12: c = a | b;
            4'd13: c = a ^ b;
            4'd14: c = ~a;
            default: c = 8'h00;
        endcase
        if (m == 4'd0 || m == 4'd15) return 17'd0;
        return {cf, (c == 8'h00), c[7], cf, of, 4'h0, c};
    endfunction

    always_comb alu_res = alu_eval(bus.alu_a, bus.alu_b, bus.alu_mode, alu_carry_q);
    assign bus.alu_c     = alu_res[7:0];
    assign bus.alu_flags = alu_res[15:8];

    // ALU carry commits once the issue window closes so DRIVE/SAMPLE see the same carry-in.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            alu_carry_q  <= 1'b0;
            alu_pend_q   <= 1'b0;
            alu_pend_v_q <= 1'b0;
        end else if (bus.alu_mode != 4'd0) begin
            alu_pend_q   <= alu_res[16];
            alu_pend_v_q <= 1'b1;
        end else if (alu_pend_v_q) begin
            alu_carry_q  <= alu_pend_q;
            alu_pend_v_q <= 1'b0;
        end
    end

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (!rst && bus.alu_mode != 4'd0) active_cnt <= active_cnt + 1;
    end

    // Scoreboard: every writeback pulse pops and checks the oldest expected writeback.
    always @(negedge clk) begin
        if (!rst && wb_valid) begin
            n_tests++;
            if (wb_q.size() == 0) begin
                n_fail++;
                $display("FAIL wb_unexpected: got reg %0d data %02h, required no writeback",
                         wb_reg, wb_data);
            end else begin
                wb_t e;
                e = wb_q.pop_front();
                if (wb_reg !== e.r || wb_data !== e.d || (cyc - accept_cyc) != WB_OFF) begin
                    n_fail++;
                    $display("FAIL wb_data: got reg %0d data %02h offset %0d, required reg %0d data %02h offset %0d",
                             wb_reg, wb_data, cyc - accept_cyc, e.r, e.d, WB_OFF);
                end
            end
        end
    end

    task automatic clear_ref();
        for (int i = 0; i < 4; i++) ref_regs[i] = 8'h00;
        ref_flags = 8'h00;
        ref_carry = 1'b0;
        wb_q.delete();
    endtask

    task automatic issue(input logic [3:0] op, input logic [1:0] dst, input logic [1:0] src,
                         input logic [7:0] imm, input logic use_imm, input logic hold);
        logic [7:0]  b;
        logic [16:0] r;
        wb_t         e;
        int          n;
        b = use_imm ? imm : ref_regs[src];
        r = alu_eval(ref_regs[dst], b, op, ref_carry);
        @(negedge clk);
        bus.instr_valid   = 1'b1;
        bus.instr_op      = op;
        bus.instr_dst     = dst;
        bus.instr_src     = src;
        bus.instr_imm     = imm;
        bus.instr_use_imm = use_imm;
        n = 0;
        while (!bus.instr_ready && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (!bus.instr_ready) begin
            n_tests++;
            n_fail++;
            $display("FAIL issue_accept: ready stayed %0b, required 1", bus.instr_ready);
            bus.instr_valid = 1'b0;
            return;
        end
        if (op != 4'd0) ref_carry = r[16];
        if (!(op == 4'd0 || op == 4'd2 || op == 4'd3 || op == 4'd15)) begin
            e.r = dst;
            e.d = r[7:0];
            wb_q.push_back(e);
            ref_regs[dst] = r[7:0];
        end
        case (op)
            4'd0:    ;
            4'd15:   ref_flags = 8'h00;
            4'd3:    ref_flags = {r[15:14], 6'b000000};
            default: ref_flags = r[15:8];
        endcase
        @(posedge clk);
        @(negedge clk);
        accept_cyc = cyc;
        if (!hold) bus.instr_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        @(negedge clk);
        while (!bus.instr_ready && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (!bus.instr_ready) begin
            n_tests++;
            n_fail++;
            $display("FAIL idle_timeout: ready %0b, required 1", bus.instr_ready);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        clear_ref();
        @(negedge clk);
        n_tests++;
        if (bus.instr_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL ready_in_reset: got %0b, required 0", bus.instr_ready);
        end
        rst = 1'b0;
        @(negedge clk);
        n_tests++;
        if (bus.instr_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL ready_after_reset: got %0b, required 1", bus.instr_ready);
        end
        for (int i = 0; i < 4; i++) begin
            rd_sel = i[1:0];
            #1;
            n_tests++;
            if (rd_data !== 8'h00) begin
                n_fail++;
                $display("FAIL reset_reg%0d: got %02h, required 00", i, rd_data);
            end
        end
        n_tests++;
        if (flags_q !== 8'h00 || bus.alu_mode !== 4'd0 || bus.alu_a !== 8'h00 ||
            bus.alu_b !== 8'h00 || wb_valid !== 1'b0 || wb_reg !== 2'd0 || wb_data !== 8'h00) begin
            n_fail++;
            $display("FAIL reset_outputs: flags %02h mode %0d a %02h b %02h wbv %0b wbr %0d wbd %02h, required all 0",
                     flags_q, bus.alu_mode, bus.alu_a, bus.alu_b, wb_valid, wb_reg, wb_data);
        end
    endtask

    task automatic test_add();
        int n;
        issue(4'd1, 2'd0, 2'd0, 8'd10, 1'b1, 1'b0);
        wait_idle();
        issue(4'd6, 2'd0, 2'd0, 8'd30, 1'b1, 1'b0);
        n = 0;
        while (!bus.instr_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        n_tests++;
        if ((cyc - accept_cyc) != RDY_OFF) begin
            n_fail++;
            $display("FAIL ready_latency: got %0d, required %0d", cyc - accept_cyc, RDY_OFF);
        end
        rd_sel = 2'd0;
        #1;
        n_tests++;
        if (rd_data !== 8'd40 || flags_q !== 8'h00) begin
            n_fail++;
            $display("FAIL add_result: r0 %0d flags %02h, required 40 and 00", rd_data, flags_q);
        end
    endtask

    task automatic test_carry_chain();
        issue(4'd1, 2'd1, 2'd0, 8'd255, 1'b1, 1'b0);
        wait_idle();
        issue(4'd6, 2'd1, 2'd0, 8'd1, 1'b1, 1'b0);
        wait_idle();
        rd_sel = 2'd1;
        #1;
        n_tests++;
        if (rd_data !== 8'h00 || flags_q !== 8'hA0) begin
            n_fail++;
            $display("FAIL add_wrap: r1 %02h flags %02h, required 00 and a0", rd_data, flags_q);
        end
        issue(4'd7, 2'd2, 2'd0, 8'd0, 1'b1, 1'b0);
        wait_idle();
        rd_sel = 2'd2;
        #1;
        n_tests++;
        if (rd_data !== 8'h01) begin
            n_fail++;
            $display("FAIL adc_carry: r2 %02h, required 01", rd_data);
        end
    endtask

    task automatic test_cmp_clear();
        issue(4'd2, 2'd0, 2'd0, 8'd50, 1'b1, 1'b0);
        wait_idle();
        rd_sel = 2'd0;
        #1;
        n_tests++;
        if (rd_data !== 8'd40 || flags_q !== 8'h60) begin
            n_fail++;
            $display("FAIL cmp: r0 %0d flags %02h, required 40 and 60", rd_data, flags_q);
        end
        issue(4'd15, 2'd0, 2'd0, 8'd0, 1'b1, 1'b0);
        wait_idle();
        n_tests++;
        if (flags_q !== 8'h00) begin
            n_fail++;
            $display("FAIL clear_flags: got %02h, required 00", flags_q);
        end
        // 40 & 0x80 is zero: TEST must report Z only.
        issue(4'd3, 2'd0, 2'd0, 8'h80, 1'b1, 1'b0);
        wait_idle();
        n_tests++;
        if (flags_q !== 8'h80 || wb_q.size() != 0) begin
            n_fail++;
            $display("FAIL test_op: flags %02h pending %0d, required 80 and 0", flags_q, wb_q.size());
        end
    endtask

    task automatic test_mixed();
        for (int i = 0; i < 12; i++) begin
            logic [3:0] op;
            logic [1:0] dst;
            op  = 4'($urandom_range(0, 15));
            dst = 2'($urandom_range(0, 3));
            issue(op, dst, 2'($urandom_range(0, 3)), 8'($urandom_range(0, 255)),
                  1'($urandom_range(0, 1)), 1'b0);
            wait_idle();
            rd_sel = dst;
            #1;
            n_tests++;
            if (rd_data !== ref_regs[dst] || flags_q !== ref_flags) begin
                n_fail++;
                $display("FAIL mixed_op%0d: r%0d %02h flags %02h, required %02h and %02h",
                         op, dst, rd_data, flags_q, ref_regs[dst], ref_flags);
            end
        end
    endtask

    task automatic test_back_to_back();
        int a0;
        int a1;
        int act0;
        wait_idle();
        act0 = active_cnt;
        issue(4'd1, 2'd1, 2'd0, 8'h11, 1'b1, 1'b1);
        a0 = accept_cyc;
        issue(4'd1, 2'd2, 2'd0, 8'h22, 1'b1, 1'b1);
        a1 = accept_cyc;
        issue(4'd1, 2'd3, 2'd0, 8'h93, 1'b1, 1'b1);
        bus.instr_valid = 1'b0;
        n_tests++;
        if ((a1 - a0) != PERIOD || (accept_cyc - a1) != PERIOD) begin
            n_fail++;
            $display("FAIL b2b_spacing: got %0d and %0d, required %0d", a1 - a0, accept_cyc - a1, PERIOD);
        end
        wait_idle();
        n_tests++;
        if ((active_cnt - act0) != 3 * ACT) begin
            n_fail++;
            $display("FAIL b2b_nop_gap: active cycles %0d, required %0d", active_cnt - act0, 3 * ACT);
        end
        rd_sel = 2'd3;
        #1;
        n_tests++;
        if (rd_data !== 8'h93 || flags_q !== 8'h40 || wb_q.size() != 0) begin
            n_fail++;
            $display("FAIL b2b_result: r3 %02h flags %02h pending %0d, required 93, 40, 0",
                     rd_data, flags_q, wb_q.size());
        end
    endtask

    task automatic test_reset_abort();
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        clear_ref();
        wait_idle();
        issue(4'd6, 2'd0, 2'd0, 8'd5, 1'b1, 1'b0);
`ifndef ALU_ISSUE_FAST_EN
        @(negedge clk);
`endif
        #1;
        rst = 1'b1;
        #1;
        n_tests++;
        if (bus.alu_mode !== 4'd0 || bus.alu_a !== 8'h00 || bus.alu_b !== 8'h00) begin
            n_fail++;
            $display("FAIL abort_ports: mode %0d a %02h b %02h, required 0", bus.alu_mode,
                     bus.alu_a, bus.alu_b);
        end
        clear_ref();
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        wait_idle();
        rd_sel = 2'd0;
        #1;
        n_tests++;
        if (rd_data !== 8'h00 || flags_q !== 8'h00) begin
            n_fail++;
            $display("FAIL abort_state: r0 %02h flags %02h, required 00 and 00", rd_data, flags_q);
        end
        issue(4'd1, 2'd3, 2'd0, 8'h5A, 1'b1, 1'b0);
        wait_idle();
        rd_sel = 2'd3;
        #1;
        n_tests++;
        if (rd_data !== 8'h5A || flags_q !== 8'h00 || wb_q.size() != 0) begin
            n_fail++;
            $display("FAIL after_abort: r3 %02h flags %02h pending %0d, required 5a, 00, 0",
                     rd_data, flags_q, wb_q.size());
        end
    endtask

    initial begin
        n_tests           = 0;
        n_fail            = 0;
        cyc               = 0;
        accept_cyc        = 0;
        active_cnt        = 0;
        rd_sel            = 2'd0;
        bus.instr_valid   = 1'b0;
        bus.instr_op      = 4'd0;
        bus.instr_dst     = 2'd0;
        bus.instr_src     = 2'd0;
        bus.instr_imm     = 8'h00;
        bus.instr_use_imm = 1'b0;
        rst               = 1'b1;
        test_reset();
        test_add();
        test_carry_chain();
        test_cmp_clear();
        test_mixed();
        test_back_to_back();
        test_reset_abort();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation still running, required completion");
        $fatal(1, "timeout");
    end

endmodule
